// File: rtl/spi_slv_pkg.sv
// Shared encodings and constants for the SPI slave register file.
package spi_slv_pkg;

   localparam int BYTE_W      = 8;
   localparam int ADDR_RW_BIT = 7;

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_ADDR = 3'b010,
      S_DATA = 3'b100
   } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a third flop for rise/fall pulse detection.
module spi_sync_edge #(
   parameter logic IDLE_VAL = 1'b1
) (
   input  logic pclk_i,
   input  logic prst_i,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [2:0] sh_q;

   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) sh_q <= {3{IDLE_VAL}};
      else        sh_q <= {sh_q[1:0], d};
   end

   assign q    = sh_q[1];
   assign rise = sh_q[1] & ~sh_q[2];
   assign fall = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/spi_slave_regs.sv
// SPI slave exposing DEPTH byte registers; LSB-first, address byte then burst data.
// Define SPI_SLV_TIMEOUT_EN to abort frames after TIMEOUT_CYC idle pclk cycles.
module spi_slave_regs
   import spi_slv_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                     pclk_i,
   input  logic                     prst_i,
   input  logic                     sclk_i,
   input  logic                     cs_n_i,
   input  logic                     mosi_i,
   output logic                     miso_o,
   input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
   output logic [7:0]               rd_data_o,
   output logic                     wr_evt_o,
   output logic [$clog2(DEPTH)-1:0] wr_idx_o,
   output logic [7:0]               wr_data_o,
   output logic                     frame_err_o
);

   localparam int IW = $clog2(DEPTH);

   state_t              state_q, state_d;
   logic                sclk_s, sclk_rise, sclk_fall;
   logic                cs_n_m, cs_n_s, mosi_m, mosi_s;
   logic [2:0]          bit_cnt_q;
   logic [BYTE_W-2:0]   rx_q;
   logic [BYTE_W-1:0]   rx_byte, tx_q;
   logic [IW-1:0]       idx_q;
   logic                is_wr_q, load_q;
   logic [BYTE_W-1:0]   mem_q [DEPTH];
   logic                byte_done, abort, tmo_hit;
   logic                unused_sclk;

   spi_sync_edge #(.IDLE_VAL(1'b1)) u_sclk_sync (
      .pclk_i (pclk_i),
      .prst_i (prst_i),
      .d      (sclk_i),
      .q      (sclk_s),
      .rise   (sclk_rise),
      .fall   (sclk_fall)
   );

   assign unused_sclk = sclk_s ^ sclk_rise;

   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
         cs_n_m <= 1'b1;
         cs_n_s <= 1'b1;
         mosi_m <= 1'b1;
         mosi_s <= 1'b1;
      end else begin
         cs_n_m <= cs_n_i;
         cs_n_s <= cs_n_m;
         mosi_m <= mosi_i;
         mosi_s <= mosi_m;
      end
   end

`ifdef SPI_SLV_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q;

   // Counts pclk cycles without any sclk activity while a frame is open.
   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i)                                           tmo_q <= '0;
      else if (state_q == S_IDLE || sclk_rise || sclk_fall) tmo_q <= '0;
      else if (!tmo_hit)                                    tmo_q <= tmo_q + 1'b1;
   end

   assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC));
`else
   assign tmo_hit = 1'b0;
`endif

   assign rx_byte   = {mosi_s, rx_q};
   assign abort     = (state_q != S_IDLE) && (cs_n_s || tmo_hit);
   assign byte_done = (state_q != S_IDLE) && sclk_fall && (bit_cnt_q == 3'd7);

   // Read data only reaches the pin while a read data phase is open.
   assign miso_o = (state_q == S_DATA && !is_wr_q && !cs_n_s) ? tx_q[0] : 1'b1;

   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (!cs_n_s) state_d = S_ADDR;
         S_ADDR:  if (abort) state_d = S_IDLE;
                  else if (byte_done) state_d = S_DATA;
         S_DATA:  if (abort) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         idx_q       <= '0;
         is_wr_q     <= 1'b0;
         load_q      <= 1'b0;
         rd_data_o   <= '0;
         wr_evt_o    <= 1'b0;
         wr_idx_o    <= '0;
         wr_data_o   <= '0;
         frame_err_o <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_evt_o    <= 1'b0;
         frame_err_o <= 1'b0;
         load_q      <= 1'b0;
         rd_data_o   <= mem_q[rd_idx_i];
         if (abort) begin
            bit_cnt_q   <= '0;
            frame_err_o <= (bit_cnt_q != 3'd0);
         end else if (state_q != S_IDLE && sclk_fall) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            rx_q      <= rx_byte[BYTE_W-1:1];
            tx_q      <= {1'b1, tx_q[BYTE_W-1:1]};
            if (byte_done) begin
               if (state_q == S_ADDR) begin
                  is_wr_q <= rx_byte[ADDR_RW_BIT];
                  idx_q   <= rx_byte[IW-1:0];
                  load_q  <= !rx_byte[ADDR_RW_BIT];
               end else begin
                  if (is_wr_q) begin
                     mem_q[idx_q] <= rx_byte;
                     wr_evt_o     <= 1'b1;
                     wr_idx_o     <= idx_q;
                     wr_data_o    <= rx_byte;
                  end else begin
                     load_q <= 1'b1;
                  end
                  idx_q <= idx_q + 1'b1;
               end
            end
         end
         // Load uses idx_q as updated by the previous cycle's byte boundary.
         if (load_q) tx_q <= mem_q[idx_q];
      end
   end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Randomized SPI frames checked against a byte-array register model via scoreboards.
module tb_spi_slave_regs;

   localparam int DEPTH = 8;
   localparam int IW    = $clog2(DEPTH);
   localparam int HALF  = 40;

   logic          pclk_i = 1'b0;
   logic          prst_i, sclk_i, cs_n_i, mosi_i, miso_o;
   logic [IW-1:0] rd_idx_i, wr_idx_o;
   logic [7:0]    rd_data_o, wr_data_o;
   logic          wr_evt_o, frame_err_o;

   int total = 0;
   int bad   = 0;

   logic [7:0]    model_mem [DEPTH];
   logic [7:0]    tx_bytes [8];
   logic [IW+7:0] exp_wr_q [$];
   logic [0:0]    exp_err_q [$];
   logic [7:0]    exp_miso_q [$];
   logic [7:0]    act_miso_q [$];
   logic [IW+7:0] mon_wr;
   logic [7:0]    mon_act, mon_exp;

   spi_slave_regs #(.DEPTH(DEPTH), .TIMEOUT_CYC(256)) dut (
      .pclk_i      (pclk_i),
      .prst_i      (prst_i),
      .sclk_i      (sclk_i),
      .cs_n_i      (cs_n_i),
      .mosi_i      (mosi_i),
      .miso_o      (miso_o),
      .rd_idx_i    (rd_idx_i),
      .rd_data_o   (rd_data_o),
      .wr_evt_o    (wr_evt_o),
      .wr_idx_o    (wr_idx_o),
      .wr_data_o   (wr_data_o),
      .frame_err_o (frame_err_o)
   );

   always #5 pclk_i = ~pclk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Controller-side bit driver: miso is captured just before each falling edge.
   task automatic spi_bits(input logic [7:0] b, input int nbits, input bit cap);
      logic [7:0] m;
      m = 8'hFF;
      for (int i = 0; i < nbits; i++) begin
         mosi_i = b[i];
         #(HALF);
         m[i]   = miso_o;
         sclk_i = 1'b0;
         #(HALF);
         sclk_i = 1'b1;
      end
      if (cap && nbits == 8) act_miso_q.push_back(m);
      #($urandom_range(0, 4) * 10);
   endtask

   // Predicts the frame's effect on the register model, then drives it.
   task automatic run_frame(input int nbytes, input int extra);
      logic          is_rd;
      logic [IW-1:0] idx;
      is_rd = 1'b0;
      idx   = '0;
      if (nbytes > 0) begin
         is_rd = !tx_bytes[0][7];
         idx   = tx_bytes[0][IW-1:0];
         for (int k = 1; k < nbytes; k++) begin
            if (is_rd) exp_miso_q.push_back(model_mem[idx]);
            else begin
               model_mem[idx] = tx_bytes[k];
               exp_wr_q.push_back({idx, tx_bytes[k]});
            end
            idx = idx + 1'b1;
         end
      end
      if (extra > 0) exp_err_q.push_back(1'b1);
      cs_n_i = 1'b0;
      #(HALF);
      for (int k = 0; k < nbytes; k++) spi_bits(tx_bytes[k], 8, is_rd && k > 0);
      if (extra > 0) spi_bits(tx_bytes[nbytes], extra, 1'b0);
      #(HALF);
      cs_n_i = 1'b1;
      #(HALF * 3);
   endtask

   task automatic check_rd(input int i);
      @(negedge pclk_i) rd_idx_i = i[IW-1:0];
      @(negedge pclk_i) check("rd_data", rd_data_o, model_mem[i]);
   endtask

   always @(negedge pclk_i) begin
      if (!prst_i) begin
         if (wr_evt_o) begin
            if (exp_wr_q.size() == 0) check("wr_evt_unexpected", wr_evt_o, 1'b0);
            else begin
               mon_wr = exp_wr_q.pop_front();
               check("wr_idx", wr_idx_o, mon_wr[IW+7:8]);
               check("wr_data", wr_data_o, mon_wr[7:0]);
            end
         end
         if (frame_err_o) begin
            if (exp_err_q.size() == 0) check("frame_err_unexpected", frame_err_o, 1'b0);
            else void'(exp_err_q.pop_front());
         end
         while (act_miso_q.size() > 0) begin
            mon_act = act_miso_q.pop_front();
            if (exp_miso_q.size() == 0) check("miso_unexpected", act_miso_q.size() + 1, 0);
            else begin
               mon_exp = exp_miso_q.pop_front();
               check("miso_byte", mon_act, mon_exp);
            end
         end
      end
   end

   initial begin
      prst_i   = 1'b1;
      sclk_i   = 1'b1;
      cs_n_i   = 1'b1;
      mosi_i   = 1'b1;
      rd_idx_i = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
      repeat (4) @(negedge pclk_i);
      check("rst_miso", miso_o, 1'b1);
      check("rst_rd_data", rd_data_o, 8'h00);
      check("rst_wr_evt", wr_evt_o, 1'b0);
      check("rst_frame_err", frame_err_o, 1'b0);
      prst_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) check_rd(i);

      // Single write, then read-back on the local port.
      tx_bytes[0] = 8'h83; tx_bytes[1] = 8'hA5;
      run_frame(2, 0);
      check_rd(3);

      // Read of a known pattern, then miso must idle high.
      tx_bytes[0] = 8'h85; tx_bytes[1] = 8'h3C;
      run_frame(2, 0);
      tx_bytes[0] = 8'h05;
      run_frame(2, 0);
      check("miso_idle", miso_o, 1'b1);

      // Write burst wrapping from the top index.
      tx_bytes[0] = 8'h87; tx_bytes[1] = 8'h11; tx_bytes[2] = 8'h22;
      run_frame(3, 0);
      check_rd(7);
      check_rd(0);

      // Partial data byte is discarded with an error pulse.
      tx_bytes[0] = 8'h84; tx_bytes[1] = 8'h5A;
      run_frame(1, 5);
      check_rd(4);

      // Read burst wrapping 6,7,0.
      tx_bytes[0] = 8'h06;
      run_frame(4, 0);

      // Reset in the middle of the address byte.
      cs_n_i = 1'b0;
      #(HALF);
      spi_bits(8'h81, 4, 1'b0);
      #3;
      prst_i = 1'b1;
      cs_n_i = 1'b1;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
      repeat (3) @(negedge pclk_i);
      check("midrst_miso", miso_o, 1'b1);
      check("midrst_rd_data", rd_data_o, 8'h00);
      check("midrst_wr_evt", wr_evt_o, 1'b0);
      check("midrst_frame_err", frame_err_o, 1'b0);
      prst_i = 1'b0;
      #(HALF * 2);
      tx_bytes[0] = 8'h81; tx_bytes[1] = 8'hFF;
      run_frame(2, 0);
      check_rd(1);
      check_rd(3);

      // Random frames of either direction, some ending mid-byte.
      for (int n = 0; n < 24; n++) begin
         int nb, ex;
         nb = $urandom_range(0, 4);
         ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         for (int k = 0; k < 8; k++) tx_bytes[k] = 8'($urandom());
         run_frame(nb, ex);
      end
      for (int i = 0; i < DEPTH; i++) check_rd(i);

`ifdef SPI_SLV_TIMEOUT_EN
      // Stalled frame times out; the following byte opens a new address.
      exp_err_q.push_back(1'b1);
      cs_n_i = 1'b0;
      #(HALF);
      spi_bits(8'h07, 3, 1'b0);
      repeat (300) @(negedge pclk_i);
      model_mem[2] = 8'h5A;
      exp_wr_q.push_back({IW'(2), 8'h5A});
      spi_bits(8'h82, 8, 1'b0);
      spi_bits(8'h5A, 8, 1'b0);
      #(HALF);
      cs_n_i = 1'b1;
      #(HALF * 3);
      check_rd(2);
`endif

      #(HALF * 5);
      check("wr_events_missing", exp_wr_q.size(), 0);
      check("frame_err_missing", exp_err_q.size(), 0);
      check("miso_bytes_missing", exp_miso_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
